// File: rtl/tgate_bus_arbiter_if.sv
// Bus between the requesters and the transmission-gate arbiter.
// Requesters drive req/done; the arbiter drives the gate enables and status.
interface tgate_bus_arbiter_if #(
  parameter int N = 4
);
  localparam int IDW = $clog2(N);

  // Handshake: req is a level held for as long as a requester wants the wire;
  // done is a one-cycle pulse from the current owner giving the wire back.
  // control is one-hot or zero, registered, and is the only gate enable source.
  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [N-1:0]   control;
  logic [IDW-1:0] grant_id;
  logic           bus_busy;
  logic           timeout;
  logic [1:0]     dbg_state;

  modport master (
    output req, done,
    input  control, grant_id, bus_busy, timeout, dbg_state
  );

  modport slave (
    input  req, done,
    output control, grant_id, bus_busy, timeout, dbg_state
  );
endinterface

// File: rtl/tgate_bus_arbiter.sv
// Round-robin arbiter producing enables for N transmission gates on one wire,
// with a bounded hold time and an all-off turnaround gap between owners.
module tgate_bus_arbiter #(
  parameter int N          = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  tgate_bus_arbiter_if.slave bus
);
  localparam int IDW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   control_q, control_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] last_ptr_q, last_ptr_d;
  logic [IDW-1:0] pick_idx;
  logic [7:0]     hold_cnt_q, hold_cnt_d;
  logic [2:0]     turn_cnt_q, turn_cnt_d;
  logic           timeout_q, timeout_d;
  logic           bus_busy_q, bus_busy_d;
  logic           pick_valid, owner_done, owner_req, at_max;
  logic           start_grant, release_now, cut_off;

  // Scan from the far end back toward last_ptr+1 so the nearest set bit wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      if (bus.req[IDW'((int'(last_ptr_q) + k) % N)]) begin
        pick_valid = 1'b1;
        pick_idx   = IDW'((int'(last_ptr_q) + k) % N);
      end
    end
  end

  assign owner_done = bus.done[grant_id_q];
  assign owner_req  = bus.req[grant_id_q];
  assign at_max     = (hold_cnt_q == 8'(MAX_HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      control_q  <= '0;
      grant_id_q <= '0;
      last_ptr_q <= IDW'(N - 1);
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
      timeout_q  <= 1'b0;
      bus_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      control_q  <= control_d;
      grant_id_q <= grant_id_d;
      last_ptr_q <= last_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      timeout_q  <= timeout_d;
      bus_busy_q <= bus_busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    turn_cnt_d  = turn_cnt_q;
    start_grant = 1'b0;
    release_now = 1'b0;
    cut_off     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          start_grant = 1'b1;
          hold_cnt_d  = 8'd1;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (owner_done || !owner_req || at_max) begin
          release_now = 1'b1;
          // A cut-off only counts when the owner still wanted the wire.
          cut_off     = at_max && !owner_done && owner_req;
          hold_cnt_d  = '0;
          turn_cnt_d  = '0;
          state_d     = (TURNAROUND > 0) ? TURN : IDLE;
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      TURN: begin
        if (int'(turn_cnt_q) >= TURNAROUND - 1) begin
          state_d    = IDLE;
          turn_cnt_d = '0;
        end else begin
          turn_cnt_d = turn_cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    control_d  = control_q;
    grant_id_d = grant_id_q;
    last_ptr_d = last_ptr_q;
    timeout_d  = 1'b0;
    if (start_grant) begin
      control_d           = '0;
      control_d[pick_idx] = 1'b1;
      grant_id_d          = pick_idx;
      last_ptr_d          = pick_idx;
    end else if (release_now) begin
      control_d = '0;
      timeout_d = cut_off;
    end
    bus_busy_d = |control_d;
  end

  assign bus.control   = control_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.bus_busy  = bus_busy_q;
  assign bus.timeout   = timeout_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_tgate_bus_arbiter.sv
// Directed bench for tgate_bus_arbiter: vector table plus hand-written
// timeout, coincident-release, fairness and asynchronous-reset sequences.
module tb_tgate_bus_arbiter;
  localparam int N          = 4;
  localparam int TURNAROUND = 1;
  localparam int MAX_HOLD   = 8;
  localparam int IDW        = $clog2(N);
  localparam int W          = N + IDW + 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_TURN  = 2'd2;

  // Shared-wire encoding: {driven, value}; 2'b00 is high-Z, 2'b01 is a conflict.
  localparam logic [1:0] WIRE_Z = 2'b00;
  localparam logic [1:0] WIRE_X = 2'b01;

  typedef struct {
    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic [N-1:0]   ctl;
    logic [IDW-1:0] gid;
    logic           to;
    logic [1:0]     st;
  } vec_t;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   gate_in;
  logic [W-1:0]   exp_q[$];
  logic [1:0]     wexp_q[$];
  int             n_cmp;
  int             n_bad;
  vec_t           vecs[22];

  tgate_bus_arbiter_if #(.N(N)) bus ();

  tgate_bus_arbiter #(
    .N(N),
    .TURNAROUND(TURNAROUND),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
    $fatal(1);
  end

  // Model of N transmission gates on one wire, gate i passing gate_in[i].
  function automatic logic [1:0] wire_now();
    logic [1:0] w;
    w = WIRE_Z;
    for (int i = 0; i < N; i++) begin
      if (bus.control[i]) w = (w == WIRE_Z) ? {1'b1, gate_in[i]} : WIRE_X;
    end
    return w;
  endfunction

  function automatic logic [1:0] wire_expect(input logic [N-1:0] ctl, input logic [IDW-1:0] gid);
    logic [1:0] w;
    w = (ctl == '0) ? WIRE_Z : {1'b1, gate_in[gid]};
    return w;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [N-1:0] ctl, input logic [IDW-1:0] gid,
                            input logic to, input logic [1:0] st);
    exp_q.push_back({ctl, gid, |ctl, to, st});
    wexp_q.push_back(wire_expect(ctl, gid));
  endtask

  task automatic sample_check(input string name);
    logic [W-1:0] exp;
    logic [1:0]   wexp;
    exp  = exp_q.pop_front();
    wexp = wexp_q.pop_front();
    check({name, " outputs{ctl,gid,busy,to,st}"},
          32'({bus.control, bus.grant_id, bus.bus_busy, bus.timeout, bus.dbg_state}), 32'(exp));
    check({name, " wire{drv,val}"}, 32'(wire_now()), 32'(wexp));
  endtask

  // ---------------- driver ----------------
  task automatic step(input string name, input logic [N-1:0] req, input logic [N-1:0] done,
                      input logic [N-1:0] ctl, input logic [IDW-1:0] gid,
                      input logic to, input logic [1:0] st);
    bus.req  = req;
    bus.done = done;
    expect_out(ctl, gid, to, st);
    @(posedge clk);
    #1;
    sample_check(name);
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    gate_in = 4'b1010;
    rst_n   = 1'b0;
    bus.req  = '0;
    bus.done = '0;

    //                req      done     ctl      gid   to    st
    vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0, S_GRANT};
    vecs[1]  = '{4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0, S_TURN};
    vecs[2]  = '{4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, S_IDLE};
    vecs[3]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0, S_GRANT};
    vecs[4]  = '{4'b1111, 4'b0010, 4'b0000, 2'd1, 1'b0, S_TURN};
    vecs[5]  = '{4'b1111, 4'b0000, 4'b0000, 2'd1, 1'b0, S_IDLE};
    vecs[6]  = '{4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b0, S_GRANT};
    vecs[7]  = '{4'b1111, 4'b0100, 4'b0000, 2'd2, 1'b0, S_TURN};
    vecs[8]  = '{4'b1111, 4'b0000, 4'b0000, 2'd2, 1'b0, S_IDLE};
    vecs[9]  = '{4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0, S_GRANT};
    vecs[10] = '{4'b1111, 4'b1000, 4'b0000, 2'd3, 1'b0, S_TURN};
    vecs[11] = '{4'b1111, 4'b0000, 4'b0000, 2'd3, 1'b0, S_IDLE};
    vecs[12] = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0, S_GRANT};
    vecs[13] = '{4'b1111, 4'b0010, 4'b0001, 2'd0, 1'b0, S_GRANT};
    vecs[14] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, S_TURN};
    vecs[15] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, S_IDLE};
    vecs[16] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, S_IDLE};
    vecs[17] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, S_GRANT};
    vecs[18] = '{4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0, S_TURN};
    vecs[19] = '{4'b0100, 4'b0000, 4'b0000, 2'd2, 1'b0, S_IDLE};
    vecs[20] = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, S_IDLE};
    vecs[21] = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, S_IDLE};

    // Reset values while rst_n is held low across an edge.
    #12;
    expect_out('0, '0, 1'b0, S_IDLE);
    sample_check("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin 0,1,2,3,0, non-owner done, req drop, then single requester.
    for (int i = 0; i < 22; i++) begin
      step($sformatf("vec%0d", i), vecs[i].req, vecs[i].done,
           vecs[i].ctl, vecs[i].gid, vecs[i].to, vecs[i].st);
    end

    // Timeout: sole requester holds for exactly MAX_HOLD cycles.
    for (int c = 1; c <= MAX_HOLD; c++) begin
      step($sformatf("t4_hold%0d", c), 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, S_GRANT);
    end
    step("t4_cut",     4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1, S_TURN);
    step("t4_turn",    4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0, S_IDLE);
    step("t4_regrant", 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, S_GRANT);
    step("t4_drop",    4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, S_TURN);
    step("t4_idle",    4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, S_IDLE);

    // done[owner] on the MAX_HOLD edge: release without timeout; done[3] ignored.
    for (int c = 1; c <= MAX_HOLD; c++) begin
      step($sformatf("t5_hold%0d", c), 4'b0010, (c == 3) ? 4'b1000 : 4'b0000,
           4'b0010, 2'd1, 1'b0, S_GRANT);
    end
    step("t5_both", 4'b0010, 4'b0010, 4'b0000, 2'd1, 1'b0, S_TURN);
    step("t5_idle", 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, S_IDLE);

    // Fairness: owner 0 cut off while 1 waits; 1 is served next.
    for (int c = 1; c <= MAX_HOLD; c++) begin
      step($sformatf("fair_hold%0d", c), 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0, S_GRANT);
    end
    step("fair_cut",  4'b0011, 4'b0000, 4'b0000, 2'd0, 1'b1, S_TURN);
    step("fair_turn", 4'b0011, 4'b0000, 4'b0000, 2'd0, 1'b0, S_IDLE);
    step("fair_next", 4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b0, S_GRANT);

    // Asynchronous reset mid-grant: enables drop with no clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    expect_out('0, '0, 1'b0, S_IDLE);
    sample_check("t1_async");
    @(posedge clk);
    #1;
    expect_out('0, '0, 1'b0, S_IDLE);
    sample_check("t1_held");
    @(negedge clk);
    rst_n = 1'b1;
    step("t1_first",  4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0, S_GRANT);
    step("t1_done",   4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, S_TURN);
    step("t1_idle",   4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, S_IDLE);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
